lab2_cmd_parser: RTL and testbench
==================================

Name: lab2_cmd_parser

Overview:
- Command front end that drives the Lab2 ASCII adder/subtractor. It is the initiator side of the adder interface.
- Consumes a byte stream from the UART receiver and parses commands of the form "<d><op><d><CR>".
- Issues the operands, the subtract flag and a one-cycle start pulse to the adder.
- Waits for the adder's ready pulse, then returns the captured 8-bit ASCII result, or an error code, to the console logic.

Parameters:
- TIMEOUT, 255: clk cycles to wait in WAIT_RDY for L2_adder_rdy before flagging a timeout. Legal range 1..65535.

Ports:
- clk  in  1  global clock; all flops rise on posedge.
- Gl_rst_n  in  1  reset, asynchronous assert, active-low. Deassertion is synchronised upstream.
- rx_data  in  8  received ASCII byte.
- rx_valid  in  1  one-cycle strobe: rx_data is valid.
- rx_ready  out  1  high when the parser accepts bytes.
- Gl_r1  out  8  first operand, raw ASCII digit.
- Gl_r2  out  8  second operand, raw ASCII digit.
- Gl_subtract  out  1  1 = r1 - r2, 0 = r1 + r2.
- Gl_adder_start  out  1  one-cycle pulse: operands ready.
- L2_adder_data  in  8  adder ASCII result; valid only with L2_adder_rdy.
- L2_adder_rdy  in  1  one-cycle pulse from the adder.
- cmd_result  out  8  captured adder result.
- cmd_result_vld  out  1  one-cycle pulse: cmd_result updated.
- cmd_err  out  1  one-cycle pulse: command failed.
- err_code  out  2  1 = bad character, 2 = ESC abort, 3 = timeout; holds its value until the next error.

Behaviour:
- Reset (Gl_rst_n low, asynchronous): state IDLE.
  - All outputs 0, except rx_ready = 1.
  - Timeout counter 0.
- All outputs are registered. Byte handling only occurs on a cycle with rx_valid & rx_ready.
- Character classes:
  - DIGIT: 0x30..0x39
  - PLUS: 0x2B
  - MINUS: 0x2D
  - CR: 0x0D
  - ESC: 0x1B
  - SP: 0x20. Ignored in every parse state with no state change.
  - Anything else is OTHER.
- States: IDLE, GOT_A, GOT_OP, GOT_B, ISSUE, WAIT_RDY.
- Transitions:
  - IDLE: DIGIT -> capture into r1_hold, go to GOT_A.
  - GOT_A: PLUS or MINUS -> sub_hold = (MINUS), go to GOT_OP.
  - GOT_OP: DIGIT -> capture into r2_hold, go to GOT_B.
  - GOT_B: CR -> go to ISSUE.
  - Unexpected byte in IDLE..GOT_B (including CR anywhere but GOT_B) -> cmd_err pulse with err_code = 1 on the next cycle, go to IDLE.
  - ESC in GOT_A, GOT_OP or GOT_B -> cmd_err pulse with err_code = 2, go to IDLE.
  - ESC in IDLE is silently ignored.
  - ISSUE, one cycle:
    - Gl_r1/Gl_r2/Gl_subtract load from the hold registers.
    - Gl_adder_start = 1 in the same cycle (operands and start present together).
    - Counter cleared; go to WAIT_RDY.
  - WAIT_RDY:
    - Gl_adder_start = 0.
    - Gl_r1/Gl_r2/Gl_subtract stay stable until the next ISSUE.
    - On L2_adder_rdy: cmd_result <= L2_adder_data and cmd_result_vld = 1 on the next cycle; go to IDLE.
    - Otherwise the counter increments. When counter == TIMEOUT-1 without rdy: cmd_err with err_code = 3, go to IDLE.
    - If rdy and timeout expiry coincide, rdy wins and no error is raised.
- rx_ready = 0 in ISSUE and WAIT_RDY. Bytes offered then are dropped without error (the console layer retries).
- L2_adder_rdy outside WAIT_RDY is ignored; cmd_result is unchanged.
- Gl_adder_start never pulses twice per command and never pulses for an erroring command.
- Reset mid-command: everything returns to the reset values immediately, with no start or err pulse.
- Latency:
  - CR accepted at cycle N -> Gl_adder_start at cycle N+1.
  - rdy at cycle M -> cmd_result_vld at cycle M+1.

Decomposition:
- Package lab2_cmd_pkg holds:
  - ASCII constants (ASC_0, ASC_9, ASC_PLUS, ASC_MINUS, ASC_CR, ASC_ESC, ASC_SP).
  - The state enum.
  - The char-class enum.
  - Error-code constants ERR_BADCHAR = 1, ERR_ABORT = 2, ERR_TIMEOUT = 3.
- One combinational sub-module, lab2_char_class: rx_data -> class.
- The FSM, hold registers and timeout counter live in lab2_cmd_parser.

Test Plan:
1. Bytes '3','+','4',CR -> Gl_adder_start pulses once, 1 cycle after CR. Gl_r1 = 0x33, Gl_r2 = 0x34, Gl_subtract = 0. Adder model returns 0x37 -> cmd_result = 0x37, cmd_result_vld 1 cycle later.
2. '9',' ','-',' ','2',CR -> Gl_subtract = 1, Gl_r1 = 0x39, Gl_r2 = 0x32. Spaces cause no error.
3. '5','x' -> cmd_err with err_code = 1, state IDLE, no start. Then '1','+','1',CR completes normally.
4. '7','+',ESC -> cmd_err with err_code = 2. A lone CR in IDLE -> err_code = 1.
5. TIMEOUT = 8, adder never responds -> cmd_err with err_code = 3, exactly 8 cycles after start. Bytes sent during WAIT_RDY are dropped and rx_ready = 0. A stray rdy afterwards is ignored.
6. Gl_rst_n pulsed low in GOT_B and again in WAIT_RDY -> all outputs 0 asynchronously, rx_ready = 1. No start or vld pulse after release.

Source files
------------

// File: rtl/lab2_cmd_pkg.sv
// Shared constants and types for the Lab2 command parser.
package lab2_cmd_pkg;

    localparam int unsigned CNT_W = 16;

    localparam logic [7:0] ASC_0     = 8'h30;
    localparam logic [7:0] ASC_9     = 8'h39;
    localparam logic [7:0] ASC_PLUS  = 8'h2B;
    localparam logic [7:0] ASC_MINUS = 8'h2D;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_ESC   = 8'h1B;
    localparam logic [7:0] ASC_SP    = 8'h20;

    localparam logic [1:0] ERR_BADCHAR = 2'd1;
    localparam logic [1:0] ERR_ABORT   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GOT_A,
        ST_GOT_OP,
        ST_GOT_B,
        ST_ISSUE,
        ST_WAIT_RDY
    } state_t;

    typedef enum logic [2:0] {
        CC_DIGIT,
        CC_PLUS,
        CC_MINUS,
        CC_CR,
        CC_ESC,
        CC_SP,
        CC_OTHER
    } char_class_t;

    // Operands and operation collected while parsing one command.
    typedef struct packed {
        logic [7:0] r1;
        logic [7:0] r2;
        logic       sub;
    } adder_req_t;

endpackage

// File: rtl/lab2_cmd_parser_if.sv
// Request/response link between the command parser and the ASCII adder.
interface lab2_cmd_parser_if;
    logic [7:0] Gl_r1;
    logic [7:0] Gl_r2;
    logic       Gl_subtract;
    logic       Gl_adder_start;
    logic [7:0] L2_adder_data;
    logic       L2_adder_rdy;

    modport master (
        output Gl_r1, Gl_r2, Gl_subtract, Gl_adder_start,
        input  L2_adder_data, L2_adder_rdy
    );

    modport slave (
        input  Gl_r1, Gl_r2, Gl_subtract, Gl_adder_start,
        output L2_adder_data, L2_adder_rdy
    );
endinterface

// File: rtl/lab2_char_class.sv
// Classifies an incoming ASCII byte for the parser.
module lab2_char_class
    import lab2_cmd_pkg::*;
(
    input  logic [7:0]  rx_data,
    output char_class_t cls_c
);

    // Digit range first, then the single-byte tokens.
    always_comb begin
        cls_c = CC_OTHER;
        if (rx_data >= ASC_0 && rx_data <= ASC_9) begin
            cls_c = CC_DIGIT;
        end else begin
            case (rx_data)
                ASC_PLUS:  cls_c = CC_PLUS;
                ASC_MINUS: cls_c = CC_MINUS;
                ASC_CR:    cls_c = CC_CR;
                ASC_ESC:   cls_c = CC_ESC;
                ASC_SP:    cls_c = CC_SP;
                default:   cls_c = CC_OTHER;
            endcase
        end
    end

endmodule

// File: rtl/lab2_cmd_parser.sv
// Parses "<d><op><d><CR>" commands, drives the adder and reports its result.
module lab2_cmd_parser
    import lab2_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              Gl_rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    lab2_cmd_parser_if.master adder,
    output logic [7:0]        cmd_result,
    output logic              cmd_result_vld,
    output logic              cmd_err,
    output logic [1:0]        err_code
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q;
    adder_req_t       hold_q;
    logic [CNT_W-1:0] cnt_q;
    char_class_t      cls_c;
    logic             byte_fire_c;
    logic             exp_ok_c;

    lab2_char_class u_char_class (
        .rx_data (rx_data),
        .cls_c   (cls_c)
    );

    assign byte_fire_c = rx_valid & rx_ready;

    // Whether the current byte is the one expected in this parse state.
    always_comb begin
        exp_ok_c = 1'b0;
        case (state_q)
            ST_IDLE:   exp_ok_c = (cls_c == CC_DIGIT);
            ST_GOT_A:  exp_ok_c = (cls_c == CC_PLUS) || (cls_c == CC_MINUS);
            ST_GOT_OP: exp_ok_c = (cls_c == CC_DIGIT);
            ST_GOT_B:  exp_ok_c = (cls_c == CC_CR);
            default:   exp_ok_c = 1'b0;
        endcase
    end

    // Command FSM with hold registers, timeout counter and registered outputs.
    always_ff @(posedge clk or negedge Gl_rst_n) begin
        if (!Gl_rst_n) begin
            state_q              <= ST_IDLE;
            hold_q               <= '0;
            cnt_q                <= '0;
            rx_ready             <= 1'b1;
            adder.Gl_r1          <= '0;
            adder.Gl_r2          <= '0;
            adder.Gl_subtract    <= 1'b0;
            adder.Gl_adder_start <= 1'b0;
            cmd_result           <= '0;
            cmd_result_vld       <= 1'b0;
            cmd_err              <= 1'b0;
            err_code             <= '0;
        end else begin
            adder.Gl_adder_start <= 1'b0;
            cmd_result_vld       <= 1'b0;
            cmd_err              <= 1'b0;
            case (state_q)
                ST_IDLE, ST_GOT_A, ST_GOT_OP, ST_GOT_B: begin
                    if (byte_fire_c && cls_c != CC_SP) begin
                        if (cls_c == CC_ESC) begin
                            // ESC only aborts a command that has started.
                            if (state_q != ST_IDLE) begin
                                cmd_err  <= 1'b1;
                                err_code <= ERR_ABORT;
                                state_q  <= ST_IDLE;
                            end
                        end else if (!exp_ok_c) begin
                            cmd_err  <= 1'b1;
                            err_code <= ERR_BADCHAR;
                            state_q  <= ST_IDLE;
                        end else begin
                            case (state_q)
                                ST_IDLE: begin
                                    hold_q.r1 <= rx_data;
                                    state_q   <= ST_GOT_A;
                                end
                                ST_GOT_A: begin
                                    hold_q.sub <= (cls_c == CC_MINUS);
                                    state_q    <= ST_GOT_OP;
                                end
                                ST_GOT_OP: begin
                                    hold_q.r2 <= rx_data;
                                    state_q   <= ST_GOT_B;
                                end
                                default: begin
                                    // Operands and start become visible together in ISSUE.
                                    adder.Gl_r1          <= hold_q.r1;
                                    adder.Gl_r2          <= hold_q.r2;
                                    adder.Gl_subtract    <= hold_q.sub;
                                    adder.Gl_adder_start <= 1'b1;
                                    cnt_q                <= '0;
                                    rx_ready             <= 1'b0;
                                    state_q              <= ST_ISSUE;
                                end
                            endcase
                        end
                    end
                end
                ST_ISSUE: begin
                    // ISSUE counts as the first waited cycle.
                    cnt_q   <= cnt_q + CNT_W'(1);
                    state_q <= ST_WAIT_RDY;
                end
                ST_WAIT_RDY: begin
                    if (adder.L2_adder_rdy) begin
                        cmd_result     <= adder.L2_adder_data;
                        cmd_result_vld <= 1'b1;
                        rx_ready       <= 1'b1;
                        state_q        <= ST_IDLE;
                    end else if (cnt_q >= TO_LAST) begin
                        cmd_err  <= 1'b1;
                        err_code <= ERR_TIMEOUT;
                        rx_ready <= 1'b1;
                        state_q  <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    rx_ready <= 1'b1;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lab2_cmd_parser.sv
// Directed self-checking bench for lab2_cmd_parser.
module tb_lab2_cmd_parser;

    logic       clk;
    logic       Gl_rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] cmd_result;
    logic       cmd_result_vld;
    logic       cmd_err;
    logic [1:0] err_code;

    int checks;
    int failures;
    int start_cnt;
    int err_cnt;
    int vld_cnt;

    lab2_cmd_parser_if adder_if ();

    lab2_cmd_parser #(.TIMEOUT(8)) dut (
        .clk            (clk),
        .Gl_rst_n       (Gl_rst_n),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .adder          (adder_if),
        .cmd_result     (cmd_result),
        .cmd_result_vld (cmd_result_vld),
        .cmd_err        (cmd_err),
        .err_code       (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (adder_if.Gl_adder_start) start_cnt++;
        if (cmd_err) err_cnt++;
        if (cmd_result_vld) vld_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic adder_reply(input logic [7:0] d);
        adder_if.L2_adder_data = d;
        adder_if.L2_adder_rdy  = 1'b1;
        tick();
        adder_if.L2_adder_rdy  = 1'b0;
    endtask

    task automatic test_reset();
        Gl_rst_n = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        adder_if.L2_adder_rdy  = 1'b0;
        adder_if.L2_adder_data = 8'h00;
        tick();
        tick();
        checks++;
        if (rx_ready !== 1'b1) begin failures++; $display("FAIL reset_rx_ready got=%b exp=1", rx_ready); end
        checks++;
        if ({adder_if.Gl_r1, adder_if.Gl_r2, adder_if.Gl_subtract, adder_if.Gl_adder_start} !== 18'h0) begin
            failures++; $display("FAIL reset_adder_outs r1=%h r2=%h sub=%b start=%b exp=0",
                adder_if.Gl_r1, adder_if.Gl_r2, adder_if.Gl_subtract, adder_if.Gl_adder_start);
        end
        checks++;
        if ({cmd_result, cmd_result_vld, cmd_err, err_code} !== 12'h0) begin
            failures++; $display("FAIL reset_cmd_outs res=%h vld=%b err=%b code=%0d exp=0",
                cmd_result, cmd_result_vld, cmd_err, err_code);
        end
        @(negedge clk);
        Gl_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_add();
        int s0;
        s0 = start_cnt;
        send(8'h33);
        send(8'h2B);
        send(8'h34);
        checks++;
        if (adder_if.Gl_adder_start !== 1'b0) begin failures++; $display("FAIL add_early_start got=%b exp=0", adder_if.Gl_adder_start); end
        send(8'h0D);
        checks++;
        if (adder_if.Gl_adder_start !== 1'b1) begin failures++; $display("FAIL add_start_latency got=%b exp=1", adder_if.Gl_adder_start); end
        checks++;
        if ({adder_if.Gl_r1, adder_if.Gl_r2, adder_if.Gl_subtract} !== {8'h33, 8'h34, 1'b0}) begin
            failures++; $display("FAIL add_operands r1=%h r2=%h sub=%b exp=33 34 0",
                adder_if.Gl_r1, adder_if.Gl_r2, adder_if.Gl_subtract);
        end
        checks++;
        if (rx_ready !== 1'b0) begin failures++; $display("FAIL add_rx_ready_issue got=%b exp=0", rx_ready); end
        tick();
        checks++;
        if (adder_if.Gl_adder_start !== 1'b0) begin failures++; $display("FAIL add_start_width got=%b exp=0", adder_if.Gl_adder_start); end
        tick();
        adder_reply(8'h37);
        checks++;
        if (cmd_result_vld !== 1'b1 || cmd_result !== 8'h37) begin
            failures++; $display("FAIL add_result vld=%b res=%h exp=1 37", cmd_result_vld, cmd_result);
        end
        checks++;
        if (rx_ready !== 1'b1) begin failures++; $display("FAIL add_rx_ready_after got=%b exp=1", rx_ready); end
        tick();
        checks++;
        if (cmd_result_vld !== 1'b0) begin failures++; $display("FAIL add_vld_width got=%b exp=0", cmd_result_vld); end
        checks++;
        if (start_cnt - s0 !== 1) begin failures++; $display("FAIL add_start_count got=%0d exp=1", start_cnt - s0); end
    endtask

    task automatic test_sub_spaces();
        int e0;
        e0 = err_cnt;
        send(8'h39);
        send(8'h20);
        send(8'h2D);
        send(8'h20);
        send(8'h32);
        send(8'h20);
        send(8'h0D);
        checks++;
        if (adder_if.Gl_adder_start !== 1'b1 ||
            {adder_if.Gl_r1, adder_if.Gl_r2, adder_if.Gl_subtract} !== {8'h39, 8'h32, 1'b1}) begin
            failures++; $display("FAIL sub_operands start=%b r1=%h r2=%h sub=%b exp=1 39 32 1",
                adder_if.Gl_adder_start, adder_if.Gl_r1, adder_if.Gl_r2, adder_if.Gl_subtract);
        end
        tick();
        adder_reply(8'h37);
        checks++;
        if (cmd_result_vld !== 1'b1 || cmd_result !== 8'h37) begin
            failures++; $display("FAIL sub_result vld=%b res=%h exp=1 37", cmd_result_vld, cmd_result);
        end
        checks++;
        if (err_cnt - e0 !== 0) begin failures++; $display("FAIL sub_space_errors got=%0d exp=0", err_cnt - e0); end
    endtask

    task automatic test_bad_char();
        int s0;
        s0 = start_cnt;
        send(8'h35);
        send(8'h78);
        checks++;
        if (cmd_err !== 1'b1 || err_code !== 2'd1) begin
            failures++; $display("FAIL bad_err err=%b code=%0d exp=1 1", cmd_err, err_code);
        end
        tick();
        checks++;
        if (cmd_err !== 1'b0 || rx_ready !== 1'b1) begin
            failures++; $display("FAIL bad_err_width err=%b rx_ready=%b exp=0 1", cmd_err, rx_ready);
        end
        checks++;
        if (start_cnt - s0 !== 0) begin failures++; $display("FAIL bad_no_start got=%0d exp=0", start_cnt - s0); end
        send(8'h31);
        send(8'h2B);
        send(8'h31);
        send(8'h0D);
        checks++;
        if (adder_if.Gl_adder_start !== 1'b1 || adder_if.Gl_r1 !== 8'h31 || adder_if.Gl_r2 !== 8'h31) begin
            failures++; $display("FAIL bad_recover start=%b r1=%h r2=%h exp=1 31 31",
                adder_if.Gl_adder_start, adder_if.Gl_r1, adder_if.Gl_r2);
        end
        tick();
        adder_reply(8'h32);
        checks++;
        if (cmd_result_vld !== 1'b1 || cmd_result !== 8'h32) begin
            failures++; $display("FAIL bad_recover_result vld=%b res=%h exp=1 32", cmd_result_vld, cmd_result);
        end
    endtask

    task automatic test_abort();
        int s0;
        s0 = start_cnt;
        send(8'h37);
        send(8'h2B);
        send(8'h1B);
        checks++;
        if (cmd_err !== 1'b1 || err_code !== 2'd2) begin
            failures++; $display("FAIL abort_err err=%b code=%0d exp=1 2", cmd_err, err_code);
        end
        send(8'h0D);
        checks++;
        if (cmd_err !== 1'b1 || err_code !== 2'd1) begin
            failures++; $display("FAIL lone_cr err=%b code=%0d exp=1 1", cmd_err, err_code);
        end
        send(8'h1B);
        checks++;
        if (cmd_err !== 1'b0 || err_code !== 2'd1) begin
            failures++; $display("FAIL idle_esc err=%b code=%0d exp=0 1", cmd_err, err_code);
        end
        checks++;
        if (start_cnt - s0 !== 0) begin failures++; $display("FAIL abort_no_start got=%0d exp=0", start_cnt - s0); end
    endtask

    task automatic test_timeout();
        int v0;
        send(8'h32);
        send(8'h2B);
        send(8'h32);
        send(8'h0D);
        for (int k = 1; k <= 8; k++) begin
            if (k >= 2 && k <= 4) begin
                rx_data  = 8'h35;
                rx_valid = 1'b1;
            end
            tick();
            rx_valid = 1'b0;
            if (k < 8) begin
                checks++;
                if (cmd_err !== 1'b0 || rx_ready !== 1'b0) begin
                    failures++; $display("FAIL timeout_wait_%0d err=%b rx_ready=%b exp=0 0", k, cmd_err, rx_ready);
                end
            end else begin
                checks++;
                if (cmd_err !== 1'b1 || err_code !== 2'd3 || rx_ready !== 1'b1) begin
                    failures++; $display("FAIL timeout_err err=%b code=%0d rx_ready=%b exp=1 3 1",
                        cmd_err, err_code, rx_ready);
                end
            end
        end
        v0 = vld_cnt;
        adder_reply(8'h55);
        tick();
        checks++;
        if (vld_cnt - v0 !== 0 || cmd_result !== 8'h32) begin
            failures++; $display("FAIL stray_rdy vlds=%0d res=%h exp=0 32", vld_cnt - v0, cmd_result);
        end
    endtask

    task automatic test_reset_mid();
        int s0;
        int e0;
        int v0;
        send(8'h38);
        send(8'h2B);
        send(8'h31);
        #2;
        Gl_rst_n = 1'b0;
        #1;
        checks++;
        if (rx_ready !== 1'b1 || cmd_err !== 1'b0 || err_code !== 2'd0 || cmd_result !== 8'h00 ||
            adder_if.Gl_r1 !== 8'h00 || adder_if.Gl_adder_start !== 1'b0) begin
            failures++; $display("FAIL rst_got_b rx_ready=%b err=%b code=%0d res=%h r1=%h start=%b exp=1 0 0 00 00 0",
                rx_ready, cmd_err, err_code, cmd_result, adder_if.Gl_r1, adder_if.Gl_adder_start);
        end
        @(negedge clk);
        Gl_rst_n = 1'b1;
        s0 = start_cnt; e0 = err_cnt; v0 = vld_cnt;
        repeat (3) tick();
        checks++;
        if (start_cnt != s0 || err_cnt != e0 || vld_cnt != v0) begin
            failures++; $display("FAIL rst_got_b_pulses start=%0d err=%0d vld=%0d exp=0 0 0",
                start_cnt - s0, err_cnt - e0, vld_cnt - v0);
        end
        send(8'h36);
        send(8'h2D);
        send(8'h31);
        send(8'h0D);
        tick();
        #2;
        Gl_rst_n = 1'b0;
        #1;
        checks++;
        if (adder_if.Gl_r1 !== 8'h00 || adder_if.Gl_r2 !== 8'h00 || adder_if.Gl_subtract !== 1'b0 ||
            rx_ready !== 1'b1) begin
            failures++; $display("FAIL rst_wait r1=%h r2=%h sub=%b rx_ready=%b exp=00 00 0 1",
                adder_if.Gl_r1, adder_if.Gl_r2, adder_if.Gl_subtract, rx_ready);
        end
        @(negedge clk);
        Gl_rst_n = 1'b1;
        s0 = start_cnt; e0 = err_cnt; v0 = vld_cnt;
        adder_reply(8'h35);
        repeat (12) tick();
        checks++;
        if (start_cnt != s0 || err_cnt != e0 || vld_cnt != v0) begin
            failures++; $display("FAIL rst_wait_pulses start=%0d err=%0d vld=%0d exp=0 0 0",
                start_cnt - s0, err_cnt - e0, vld_cnt - v0);
        end
        send(8'h32);
        send(8'h2B);
        send(8'h33);
        send(8'h0D);
        tick();
        adder_reply(8'h35);
        checks++;
        if (cmd_result_vld !== 1'b1 || cmd_result !== 8'h35) begin
            failures++; $display("FAIL rst_recover vld=%b res=%h exp=1 35", cmd_result_vld, cmd_result);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        start_cnt = 0;
        err_cnt = 0;
        vld_cnt = 0;
        test_reset();
        test_basic_add();
        test_sub_spaces();
        test_bad_char();
        test_abort();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
